// File: rtl/metrics_counter_bank.sv
// Bank of independent cycle/event counters with per-channel clear, saturate/wrap,
// sticky overflow and a global atomic snapshot into shadow registers.
module metrics_counter_bank #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int INC_WIDTH     = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_COUNTERS-1:0]                        en,
  input  logic [NUM_COUNTERS-1:0]                        clear,
  input  logic [NUM_COUNTERS-1:0]                        mode_cycle,
  input  logic [NUM_COUNTERS-1:0]                        sat_mode,
  input  logic [NUM_COUNTERS-1:0][INC_WIDTH-1:0]         event_inc,
  input  logic                                           snapshot,
  input  logic                                           snapshot_clear,
  output logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0]     cnt,
  output logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0]     snap_cnt,
  output logic                                           snap_valid,
  output logic [NUM_COUNTERS-1:0]                        overflow,
  output logic                                           overflow_irq
);

  localparam int SW = COUNTER_WIDTH + 1;

  logic [NUM_COUNTERS-1:0][SW-1:0] inc;
  logic [NUM_COUNTERS-1:0][SW-1:0] sum;
  logic [NUM_COUNTERS-1:0]         carry;
  logic [NUM_COUNTERS-1:0]         carry_kept;
  logic                            snap_zero;

  assign snap_zero = snapshot & snapshot_clear;

  // A zero increment can never carry, so a saturated idle channel stays quiet.
  always_comb begin
    inc        = '0;
    sum        = '0;
    carry      = '0;
    carry_kept = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (en[i]) begin
        inc[i] = mode_cycle[i] ? SW'(1) : SW'(event_inc[i]);
      end
      sum[i]        = {1'b0, cnt[i]} + inc[i];
      carry[i]      = sum[i][COUNTER_WIDTH];
      carry_kept[i] = carry[i] & ~clear[i] & ~snap_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      snap_cnt     <= '0;
      overflow     <= '0;
      snap_valid   <= 1'b0;
      overflow_irq <= 1'b0;
    end else begin
      snap_valid   <= snapshot;
      overflow_irq <= |carry_kept;
      // Capture the pre-update values so clears this cycle do not leak in.
      if (snapshot) begin
        snap_cnt <= cnt;
      end
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (clear[i]) begin
          cnt[i]      <= '0;
          overflow[i] <= 1'b0;
        end else if (snap_zero) begin
          cnt[i] <= '0;
        end else if (carry[i]) begin
          overflow[i] <= 1'b1;
          cnt[i]      <= sat_mode[i] ? '1 : sum[i][COUNTER_WIDTH-1:0];
        end else begin
          cnt[i] <= sum[i][COUNTER_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Randomised and directed bench for metrics_counter_bank with an integer reference
// model; expectations are queued by the driver and checked by independent monitors.
module tb_metrics_counter_bank;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int I  = 4;
  localparam int NW = N * W;
  localparam int EW = 2 * NW + N + 2;
  localparam int MAXV = (1 << W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         en, clear, mode_cycle, sat_mode;
  logic [N-1:0][I-1:0]  event_inc;
  logic                 snapshot, snapshot_clear;
  logic [N-1:0][W-1:0]  cnt, snap_cnt;
  logic                 snap_valid;
  logic [N-1:0]         overflow;
  logic                 overflow_irq;

  metrics_counter_bank #(.NUM_COUNTERS(N), .COUNTER_WIDTH(W), .INC_WIDTH(I)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode_cycle(mode_cycle),
    .sat_mode(sat_mode), .event_inc(event_inc), .snapshot(snapshot),
    .snapshot_clear(snapshot_clear), .cnt(cnt), .snap_cnt(snap_cnt),
    .snap_valid(snap_valid), .overflow(overflow), .overflow_irq(overflow_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int                  m_cnt [N];
  bit                  m_ov  [N];
  logic [N-1:0][W-1:0] m_snap;

  logic [EW-1:0] exp_q [$];
  logic [NW-1:0] snap_q [$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // driver: model the effect of the current inputs, then apply one clock edge
  task automatic step();
    logic [N-1:0][W-1:0] e_cnt;
    logic [N-1:0]        e_ov;
    logic                e_sv, e_irq, push_snap;
    logic [NW-1:0]       snap_val;
    int                  inc, sum;
    e_irq = 1'b0;
    push_snap = 1'b0;
    snap_val = '0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_ov[i] = 0; end
      m_snap = '0;
      e_sv = 1'b0;
    end else begin
      e_sv = snapshot;
      if (snapshot) begin
        for (int i = 0; i < N; i++) m_snap[i] = W'(m_cnt[i]);
        push_snap = 1'b1;
        snap_val = m_snap;
      end
      for (int i = 0; i < N; i++) begin
        inc = !en[i] ? 0 : (mode_cycle[i] ? 1 : int'(event_inc[i]));
        sum = m_cnt[i] + inc;
        if (clear[i]) begin
          m_cnt[i] = 0; m_ov[i] = 0;
        end else if (snapshot && snapshot_clear) begin
          m_cnt[i] = 0;
        end else if (sum > MAXV) begin
          m_ov[i] = 1; e_irq = 1'b1;
          m_cnt[i] = sat_mode[i] ? MAXV : sum - (MAXV + 1);
        end else begin
          m_cnt[i] = sum;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      e_cnt[i] = W'(m_cnt[i]);
      e_ov[i]  = m_ov[i];
    end
    @(posedge clk);
    exp_q.push_back({e_cnt, m_snap, e_ov, e_sv, e_irq});
    if (push_snap) snap_q.push_back(snap_val);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; en = '0; clear = '0; mode_cycle = '0; sat_mode = '0;
    event_inc = '0; snapshot = 1'b0; snapshot_clear = 1'b0;
  endtask

  // monitor: per-cycle outputs, plus snapshot contents whenever snap_valid is seen
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cnt",          cnt,          e[EW-1 -: NW]);
      chk("snap_cnt",     snap_cnt,     e[EW-1-NW -: NW]);
      chk("overflow",     overflow,     e[N+1:2]);
      chk("snap_valid",   snap_valid,   e[1]);
      chk("overflow_irq", overflow_irq, e[0]);
    end
    if (snap_valid === 1'b1) begin
      if (snap_q.size() == 0) begin
        checks++;
        $display("FAIL snap_pop actual=unexpected_pulse expected=no_pulse at %0t", $time);
      end else begin
        chk("snap_pop", snap_cnt, snap_q.pop_front());
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    idle();

    // cycle counting on channel 0 only
    en[0] = 1'b1; mode_cycle[0] = 1'b1;
    repeat (10) step();
    idle();

    // channel 1 wrap: climb to 0xFE, then +3 wraps to 0x01
    en[1] = 1'b1; event_inc[1] = 4'hF;
    repeat (16) step();
    event_inc[1] = 4'hE; step();
    event_inc[1] = 4'h3; step();
    en[1] = 1'b0; repeat (3) step();
    clear[1] = 1'b1; step();
    idle();

    // channel 2 saturate: climb to 0xFD, then repeated +15
    en[2] = 1'b1; sat_mode[2] = 1'b1; event_inc[2] = 4'hF;
    repeat (16) step();
    event_inc[2] = 4'hD; step();
    event_inc[2] = 4'hF; repeat (3) step();
    event_inc[2] = 4'h0; repeat (2) step();
    idle();

    // snapshot with snapshot_clear and clear[3]
    clear = '1; step(); idle();
    en[0] = 1'b1; mode_cycle[0] = 1'b1; en[3] = 1'b1; event_inc[3] = 4'h5;
    repeat (17) step();
    en = '0; repeat (15) begin en[0] = 1'b1; step(); end
    idle();
    snapshot = 1'b1; snapshot_clear = 1'b1; clear[3] = 1'b1; step();
    idle(); repeat (2) step();

    // back-to-back snapshots, then reset mid-count with snapshot high
    en = '1; mode_cycle = '1;
    repeat (4) step();
    snapshot = 1'b1; repeat (3) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; snapshot = 1'b0; repeat (3) step();
    idle();

    // clear overrides enable for 3 cycles
    en[0] = 1'b1; mode_cycle[0] = 1'b1; clear[0] = 1'b1;
    repeat (3) step();
    clear[0] = 1'b0; repeat (2) step();
    idle();

    // randomised traffic
    repeat (600) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      en             = N'($urandom);
      clear          = N'(($urandom_range(0, 15) == 0) ? $urandom : 0);
      mode_cycle     = N'($urandom);
      sat_mode       = N'($urandom);
      event_inc      = (N*I)'($urandom);
      snapshot       = ($urandom_range(0, 5) == 0);
      snapshot_clear = $urandom_range(0, 1) == 1;
      step();
    end
    idle();
    step();

    for (int k = 0; k < 20 && (exp_q.size() != 0 || snap_q.size() != 0); k++) @(negedge clk);
    @(negedge clk);
    #1;
    chk("drain", 64'(exp_q.size() + snap_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
